// File: rtl/load_store_unit.sv
// Byte/half/word loads and stores onto a word-wide RAM port pair; sub-word stores use read-modify-write.
// Define LSU_FAULT_CHECK_EN to report mem_ready=0 as an error and suppress the faulting write.
module load_store_unit #(
  parameter int BUS_WIDTH = 32,
  parameter int ADDR_BASE = 10,
  parameter int MEM_SIZE  = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [BUS_WIDTH-1:0] req_addr,
  input  logic [BUS_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [BUS_WIDTH-1:0] resp_rdata,
  output logic                 resp_error,
  output logic                 mem_write_en,
  output logic [BUS_WIDTH-1:0] mem_addr_write,
  output logic [BUS_WIDTH-1:0] mem_data_write,
  output logic [BUS_WIDTH-1:0] mem_addr_read,
  input  logic [BUS_WIDTH-1:0] mem_data_read,
  input  logic                 mem_ready
);

  if (BUS_WIDTH != 32) begin : g_bad_width
    $error("load_store_unit supports BUS_WIDTH=32 only");
  end
  if (MEM_SIZE < 1 || ADDR_BASE < 0) begin : g_bad_mem
    $error("load_store_unit: invalid ADDR_BASE/MEM_SIZE");
  end

  typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

  state_t state_q, state_d;

  logic                 accept;
  logic                 misaligned;
  logic                 word_store;
  logic                 mem_fault;
  logic [BUS_WIDTH-1:0] req_word;

`ifdef LSU_FAULT_CHECK_EN
  assign mem_fault = ~mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_fault        = 1'b0;
`endif

  assign accept     = req_valid & req_ready;
  assign req_word   = {2'b00, req_addr[BUS_WIDTH-1:2]};
  assign word_store = req_write & (req_size == 2'd2);
  assign misaligned = (req_size == 2'd3)
                    | ((req_size == 2'd1) & req_addr[0])
                    | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  // Latched request fields, live from accept until the response
  logic [BUS_WIDTH-1:0] word_addr_q, word_addr_d;
  logic [1:0]           size_q, size_d;
  logic [1:0]           lane_q, lane_d;
  logic                 uns_q, uns_d;
  logic                 wr_q, wr_d;
  logic [15:0]          wdata_q, wdata_d;

  logic [BUS_WIDTH-1:0] mem_addr_read_q, mem_addr_read_d;
  logic [BUS_WIDTH-1:0] mem_addr_write_q, mem_addr_write_d;
  logic [BUS_WIDTH-1:0] mem_data_write_q, mem_data_write_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_error_q, resp_error_d;
  logic [BUS_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [BUS_WIDTH-1:0] load_ext;
  logic [BUS_WIDTH-1:0] merged;

  always_ff @(posedge clk) begin
    if (!nreset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept && !misaligned) state_d = word_store ? WR : RD;
      end
      RD:  state_d = CAP;
      CAP: state_d = (mem_fault || !wr_q) ? IDLE : WR;
      WR:  state_d = IDLE;
    endcase
  end

  // Gating with nreset keeps every output low while reset is held and stops a write at the reset edge
  always_comb begin
    req_ready    = nreset & (state_q == IDLE);
    mem_write_en = nreset & (state_q == WR) & ~mem_fault;
  end

  always_comb begin
    ld_byte = mem_data_read[{lane_q, 3'b000} +: 8];
    ld_half = mem_data_read[{lane_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'd0:    load_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    load_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: load_ext = mem_data_read;
    endcase
    merged = mem_data_read;
    if (size_q == 2'd0) merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
    else                merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_comb begin
    word_addr_d      = word_addr_q;
    size_d           = size_q;
    lane_d           = lane_q;
    uns_d            = uns_q;
    wr_d             = wr_q;
    wdata_d          = wdata_q;
    mem_addr_read_d  = mem_addr_read_q;
    mem_addr_write_d = mem_addr_write_q;
    mem_data_write_d = mem_data_write_q;
    resp_valid_d     = 1'b0;
    resp_error_d     = 1'b0;
    resp_rdata_d     = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          word_addr_d = req_word;
          size_d      = req_size;
          lane_d      = req_addr[1:0];
          uns_d       = req_unsigned;
          wr_d        = req_write;
          wdata_d     = req_wdata[15:0];
          if (misaligned) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            mem_addr_read_d = req_word;
            if (word_store) begin
              mem_addr_write_d = req_word;
              mem_data_write_d = req_wdata;
            end
          end
        end
      end
      RD: ;
      CAP: begin
        if (mem_fault) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else if (!wr_q) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = load_ext;
        end else begin
          mem_addr_write_d = word_addr_q;
          mem_data_write_d = merged;
        end
      end
      WR: begin
        resp_valid_d = 1'b1;
        resp_error_d = mem_fault;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      word_addr_q      <= '0;
      size_q           <= '0;
      lane_q           <= '0;
      uns_q            <= 1'b0;
      wr_q             <= 1'b0;
      wdata_q          <= '0;
      mem_addr_read_q  <= '0;
      mem_addr_write_q <= '0;
      mem_data_write_q <= '0;
      resp_valid_q     <= 1'b0;
      resp_error_q     <= 1'b0;
      resp_rdata_q     <= '0;
    end else begin
      word_addr_q      <= word_addr_d;
      size_q           <= size_d;
      lane_q           <= lane_d;
      uns_q            <= uns_d;
      wr_q             <= wr_d;
      wdata_q          <= wdata_d;
      mem_addr_read_q  <= mem_addr_read_d;
      mem_addr_write_q <= mem_addr_write_d;
      mem_data_write_q <= mem_data_write_d;
      resp_valid_q     <= resp_valid_d;
      resp_error_q     <= resp_error_d;
      resp_rdata_q     <= resp_rdata_d;
    end
  end

  assign mem_addr_read  = mem_addr_read_q;
  assign mem_addr_write = mem_addr_write_q;
  assign mem_data_write = mem_data_write_q;
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a request-level model predicts each response and its timing; a RAM stand-in serves the DUT.
module tb_load_store_unit;
  localparam int BASE = 10;
  localparam int SIZE = 32;
`ifdef LSU_FAULT_CHECK_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        mem_write_en, mem_ready;
  logic [31:0] mem_addr_write, mem_data_write, mem_addr_read, mem_data_read;

  always #5 clk = ~clk;

  load_store_unit #(.BUS_WIDTH(32), .ADDR_BASE(BASE), .MEM_SIZE(SIZE)) dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .mem_write_en(mem_write_en),
    .mem_addr_write(mem_addr_write), .mem_data_write(mem_data_write),
    .mem_addr_read(mem_addr_read), .mem_data_read(mem_data_read),
    .mem_ready(mem_ready)
  );

  // RAM stand-in: registered read, in-range flag, write at the edge
  logic [31:0] ram [0:SIZE-1];
  logic [31:0] ram_rd_q = 32'h0;
  int          wcnt = 0;
  assign mem_ready     = (mem_addr_read >= 32'(BASE)) && (mem_addr_read < 32'(BASE + SIZE));
  assign mem_data_read = ram_rd_q;
  always @(posedge clk) begin
    ram_rd_q <= mem_ready ? ram[int'(mem_addr_read) - BASE] : 32'h0;
    if (mem_write_en) wcnt <= wcnt + 1;
    if (mem_write_en && mem_addr_write >= 32'(BASE) && mem_addr_write < 32'(BASE + SIZE))
      ram[int'(mem_addr_write) - BASE] <= mem_data_write;
  end

  typedef struct {
    int          due;
    bit          wr;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] ref_mem [0:SIZE-1];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;
  logic [31:0] last_rdata;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic want);
    chk32(nm, {31'b0, act}, {31'b0, want});
  endtask

  // Per-cycle compare against the head of the expectation queue
  always @(negedge clk) begin
    bit   ev, ew, er;
    exp_t f;
    if (chk_en && nreset) begin
      ev = 1'b0; ew = 1'b0; er = (expq.size() == 0);
      if (expq.size() > 0) begin
        f  = expq[0];
        ev = (f.due == cyc);
        ew = f.wr && (f.due - 1 == cyc);
        er = ev;
      end
      chk1("resp_valid", resp_valid, ev);
      chk1("mem_write_en", mem_write_en, ew);
      chk1("req_ready", req_ready, er);
      if (ev) begin
        chk32("resp_rdata", resp_rdata, f.rdata);
        chk1("resp_error", resp_error, f.err);
        last_rdata = resp_rdata;
        last_err   = resp_error;
        void'(expq.pop_front());
      end
    end
  end

  // Caller is positioned just after a falling edge; returns at the same phase once the response is seen
  task automatic do_req(input string nm, input bit wr, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] lit_rd, input bit lit_err);
    exp_t        e;
    int          lat, idx, sh, n;
    bit          mis, inr;
    logic [31:0] w, mask, nw;
    mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    inr = (int'(a >> 2) >= BASE) && (int'(a >> 2) < BASE + SIZE);
    idx = inr ? int'(a >> 2) - BASE : 0;
    w   = inr ? ref_mem[idx] : 32'h0;
    sh  = 8 * int'(a[1:0]);
    e.err = mis; e.rdata = 32'h0; e.wr = 1'b0;
    if (mis) lat = 0;
    else if (FAULT && !inr) begin
      e.err = 1'b1;
      lat   = (wr && sz == 2'd2) ? 1 : 2;
    end else if (!wr) begin
      lat = 2;
      if (sz == 2'd0) begin
        e.rdata = (w >> sh) & 32'hFF;
        if (!uns && e.rdata >= 32'h80) e.rdata = e.rdata | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
        e.rdata = (w >> sh) & 32'hFFFF;
        if (!uns && e.rdata >= 32'h8000) e.rdata = e.rdata | 32'hFFFF_0000;
      end else e.rdata = w;
    end else begin
      e.wr = 1'b1;
      lat  = (sz == 2'd2) ? 1 : 3;
      if (sz == 2'd0)      begin mask = 32'hFF << sh;   nw = (w & ~mask) | ((wd & 32'hFF) << sh); end
      else if (sz == 2'd1) begin mask = 32'hFFFF << sh; nw = (w & ~mask) | ((wd & 32'hFFFF) << sh); end
      else nw = wd;
      if (inr) ref_mem[idx] = nw;
    end
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!req_ready) chk1({nm, " accept timeout"}, req_ready, 1'b1);
    e.due = cyc + 1 + lat;
    expq.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'hDEAD_BEEF; req_wdata = 32'h5555_5555; req_write = ~wr;
    n = 0;
    while (expq.size() > 0 && n < 50) begin @(negedge clk); #1; n++; end
    if (expq.size() > 0) begin
      chk1({nm, " response timeout"}, 1'b0, 1'b1);
      expq.delete();
    end
    chk32({nm, " rdata literal"}, last_rdata, lit_rd);
    chk1({nm, " error literal"}, last_err, lit_err);
  endtask

  task automatic chk_all_zero(input string nm);
    chk1({nm, " req_ready"}, req_ready, 1'b0);
    chk1({nm, " resp_valid"}, resp_valid, 1'b0);
    chk1({nm, " resp_error"}, resp_error, 1'b0);
    chk1({nm, " mem_write_en"}, mem_write_en, 1'b0);
    chk32({nm, " resp_rdata"}, resp_rdata, 32'h0);
    chk32({nm, " mem_addr_read"}, mem_addr_read, 32'h0);
    chk32({nm, " mem_addr_write"}, mem_addr_write, 32'h0);
    chk32({nm, " mem_data_write"}, mem_data_write, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    for (int i = 0; i < SIZE; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    nreset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    last_rdata = 32'h0; last_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    nreset = 1'b1;
    @(negedge clk); #1;
    chk1("ready after reset", req_ready, 1'b1);
    chk_en = 1'b1;

    // name, wr, size, unsigned, addr, wdata, literal rdata, literal error
    do_req("SW 40",   1, 2'd2, 0, 32'd40, 32'h1122_3344, 32'h0,         0);
    do_req("LW 40",   0, 2'd2, 0, 32'd40, 32'h0,         32'h1122_3344, 0);
    do_req("SB 41",   1, 2'd0, 0, 32'd41, 32'hFFFF_FFAA, 32'h0,         0);
    do_req("LW 40b",  0, 2'd2, 0, 32'd40, 32'h0,         32'h1122_AA44, 0);
    do_req("LB 41",   0, 2'd0, 0, 32'd41, 32'h0,         32'hFFFF_FFAA, 0);
    do_req("LBU 41",  0, 2'd0, 1, 32'd41, 32'h0,         32'h0000_00AA, 0);
    do_req("SH 42",   1, 2'd1, 0, 32'd42, 32'h1234_BEEF, 32'h0,         0);
    do_req("LH 42",   0, 2'd1, 0, 32'd42, 32'h0,         32'hFFFF_BEEF, 0);
    do_req("LW 40c",  0, 2'd2, 0, 32'd40, 32'h0,         32'hBEEF_AA44, 0);
    do_req("LW 42",   0, 2'd2, 0, 32'd42, 32'h0,         32'h0,         1);
    do_req("SH 41",   1, 2'd1, 0, 32'd41, 32'h0000_7777, 32'h0,         1);
    do_req("SZ3 40",  0, 2'd3, 0, 32'd40, 32'h0,         32'h0,         1);
    do_req("LHU 42",  0, 2'd1, 1, 32'd42, 32'h0,         32'h0000_BEEF, 0);
    do_req("SB 47",   1, 2'd0, 0, 32'd47, 32'h0000_005A, 32'h0,         0);
    do_req("LB 47",   0, 2'd0, 0, 32'd47, 32'h0,         32'h0000_005A, 0);
    do_req("SH 44",   1, 2'd1, 0, 32'd44, 32'h0000_8001, 32'h0,         0);
    do_req("LH 44",   0, 2'd1, 0, 32'd44, 32'h0,         32'hFFFF_8001, 0);
    do_req("LW 44",   0, 2'd2, 0, 32'd44, 32'h0,         32'h5A00_8001, 0);
`ifdef LSU_FAULT_CHECK_EN
    do_req("SW 168",  1, 2'd2, 0, 32'd168, 32'hCAFE_F00D, 32'h0,        1);
    do_req("SB 170",  1, 2'd0, 0, 32'd170, 32'h0000_0011, 32'h0,        1);
`else
    do_req("SW 168",  1, 2'd2, 0, 32'd168, 32'hCAFE_F00D, 32'h0,        0);
`endif
    do_req("LW 164",  0, 2'd2, 0, 32'd164, 32'h0,        32'h0,         0);

    // Abort a sub-word store while it sits in CAP
    chk_en = 1'b0;
    w0 = wcnt;
    req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd40;
    req_wdata = 32'h0000_0077; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("abort");
    @(posedge clk); #1;
    chk_all_zero("abort hold");
    nreset = 1'b1;
    @(negedge clk); #1;
    chk32("abort write count", 32'(wcnt), 32'(w0));
    chk_en = 1'b1;
    do_req("LW 40 after abort", 0, 2'd2, 0, 32'd40, 32'h0, 32'hBEEF_AA44, 0);

    chk32("ram word 10", ram[0], 32'hBEEF_AA44);
    chk32("ram word 11", ram[1], 32'h5A00_8001);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
